calc_entry_fsm: RTL and testbench

CALC_ENTRY_FSM -- requirements
Module: calc_entry_fsm

---
 rtl/calc_entry_fsm.sv | 184 ++++++++++++++++++
 tb/tb_calc_entry_fsm.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_entry_fsm.sv
// Four-bit signed calculator entry controller: synchronised buttons drive an
// operand/operation entry FSM that registers a saturated 6-bit result.
module calc_entry_fsm #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic [1:0] op_sel,
  input  logic       btn_enter,
  input  logic       btn_mode,
  input  logic       btn_clear,
  output logic [5:0] data,
  output logic       data_valid,
  output logic       overflow,
  output logic       display_mode,
  output logic [1:0] state
);

  localparam int unsigned NUM_BTN = 3;
  localparam int unsigned BTN_ENTER = 0;
  localparam int unsigned BTN_MODE  = 1;
  localparam int unsigned BTN_CLEAR = 2;

  typedef enum logic [1:0] {
    S_A   = 2'b00,
    S_B   = 2'b01,
    S_OP  = 2'b10,
    S_RES = 2'b11
  } state_t;

  logic [NUM_BTN-1:0][SYNC_STAGES-1:0] sync_q;
  logic [NUM_BTN-1:0]                  btn_raw;
  logic [NUM_BTN-1:0]                  level;
  logic [NUM_BTN-1:0]                  prev_q;
  logic [NUM_BTN-1:0]                  pulse;
  logic                                enter_pulse;
  logic                                mode_pulse;
  logic                                clear_pulse;

  state_t            state_q;
  state_t            state_next;
  logic [3:0]        a_q;
  logic [3:0]        b_q;
  logic [3:0]        a_next;
  logic [3:0]        b_next;
  logic [5:0]        data_next;
  logic              valid_next;
  logic              ovf_next;
  logic              mode_next;

  logic [5:0]        a6;
  logic [5:0]        b6;
  logic signed [7:0] a8;
  logic signed [7:0] b8;
  logic signed [7:0] prod;
  logic [3:0]        and4;
  logic [5:0]        result;
  logic              result_ovf;

  assign btn_raw = {btn_clear, btn_mode, btn_enter};

  // Synchroniser chains plus the previous-level flop for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_BTN); i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
      end
      prev_q <= level;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      level[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  assign pulse       = level & ~prev_q;
  assign enter_pulse = pulse[BTN_ENTER];
  assign mode_pulse  = pulse[BTN_MODE];
  assign clear_pulse = pulse[BTN_CLEAR];

  // Result of the selected operation on the captured operands
  always_comb begin
    a6         = {{2{a_q[3]}}, a_q};
    b6         = {{2{b_q[3]}}, b_q};
    a8         = {{4{a_q[3]}}, a_q};
    b8         = {{4{b_q[3]}}, b_q};
    prod       = a8 * b8;
    and4       = a_q & b_q;
    result     = '0;
    result_ovf = 1'b0;
    case (op_sel)
      2'b00: result = a6 + b6;
      2'b01: result = a6 - b6;
      2'b10: begin
        if (prod > 8'sd31) begin
          result     = 6'b011111;
          result_ovf = 1'b1;
        end else if (prod < -8'sd32) begin
          result     = 6'b100000;
          result_ovf = 1'b1;
        end else begin
          result = prod[5:0];
        end
      end
      default: result = {{2{and4[3]}}, and4};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_A;
    end else begin
      state_q <= state_next;
    end
  end

  // Next state: clear wins over enter
  always_comb begin
    state_next = state_q;
    if (clear_pulse) begin
      state_next = S_A;
    end else if (enter_pulse) begin
      case (state_q)
        S_A:     state_next = S_B;
        S_B:     state_next = S_OP;
        S_OP:    state_next = S_RES;
        default: state_next = S_A;
      endcase
    end
  end

  // Next values of operands and result registers; mode toggles independently
  always_comb begin
    a_next     = a_q;
    b_next     = b_q;
    data_next  = data;
    valid_next = data_valid;
    ovf_next   = overflow;
    mode_next  = display_mode ^ mode_pulse;
    if (clear_pulse) begin
      data_next  = '0;
      valid_next = 1'b0;
      ovf_next   = 1'b0;
    end else if (enter_pulse) begin
      case (state_q)
        S_A: a_next = sw;
        S_B: b_next = sw;
        S_OP: begin
          data_next  = result;
          ovf_next   = result_ovf;
          valid_next = 1'b1;
        end
        default: valid_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q          <= '0;
      b_q          <= '0;
      data         <= '0;
      data_valid   <= 1'b0;
      overflow     <= 1'b0;
      display_mode <= 1'b0;
    end else begin
      a_q          <= a_next;
      b_q          <= b_next;
      data         <= data_next;
      data_valid   <= valid_next;
      overflow     <= ovf_next;
      display_mode <= mode_next;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Bench for calc_entry_fsm: directed vector table, corner sequences and random
// stimulus, all checked cycle by cycle against a time-indexed reference model.
module tb_calc_entry_fsm;

  localparam int S    = 2;
  localparam int MAXC = 8192;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic [1:0] op_sel;
  logic       btn_enter;
  logic       btn_mode;
  logic       btn_clear;
  logic [5:0] data;
  logic       data_valid;
  logic       overflow;
  logic       display_mode;
  logic [1:0] state;

  calc_entry_fsm #(.SYNC_STAGES(S)) dut (
    .clk          (clk),
    .reset        (reset),
    .sw           (sw),
    .op_sel       (op_sel),
    .btn_enter    (btn_enter),
    .btn_mode     (btn_mode),
    .btn_clear    (btn_clear),
    .data         (data),
    .data_valid   (data_valid),
    .overflow     (overflow),
    .display_mode (display_mode),
    .state        (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: raw button levels logged per clock edge
  bit raw_e[MAXC];
  bit raw_m[MAXC];
  bit raw_c[MAXC];
  int cyc_n    = 0;
  int last_rst = -1;
  int m_a, m_b, m_state, m_data;
  bit m_dv, m_ov, m_mode;

  // Synchronised level seen at edge k+S is the raw level sampled at edge k
  function automatic bit lvl(input int which, input int k);
    if (k < 0 || k <= last_rst) return 1'b0;
    case (which)
      0:       return raw_e[k];
      1:       return raw_m[k];
      default: return raw_c[k];
    endcase
  endfunction

  function automatic bit pulse_at(input int which, input int j);
    return lvl(which, j - S) && !lvl(which, j - S - 1);
  endfunction

  task automatic model_step();
    bit pe, pm, pc;
    int p;
    if (cyc_n >= MAXC) begin
      $display("FAIL cycle_budget: used %0d cycles, limit %0d", cyc_n, MAXC);
      $fatal(1, "cycle budget exceeded");
    end
    raw_e[cyc_n] = btn_enter;
    raw_m[cyc_n] = btn_mode;
    raw_c[cyc_n] = btn_clear;
    if (reset) begin
      last_rst = cyc_n;
      m_a = 0; m_b = 0; m_state = 0; m_data = 0;
      m_dv = 0; m_ov = 0; m_mode = 0;
    end else begin
      pe = pulse_at(0, cyc_n);
      pm = pulse_at(1, cyc_n);
      pc = pulse_at(2, cyc_n);
      if (pm) m_mode = !m_mode;
      if (pc) begin
        m_state = 0; m_data = 0; m_dv = 0; m_ov = 0;
      end else if (pe) begin
        if (m_state == 0) begin
          m_a = int'($signed(sw)); m_state = 1;
        end else if (m_state == 1) begin
          m_b = int'($signed(sw)); m_state = 2;
        end else if (m_state == 2) begin
          m_ov = 0;
          case (op_sel)
            2'b00: m_data = m_a + m_b;
            2'b01: m_data = m_a - m_b;
            2'b10: begin
              p = m_a * m_b;
              if (p > 31) begin m_data = 31; m_ov = 1; end
              else if (p < -32) begin m_data = -32; m_ov = 1; end
              else m_data = p;
            end
            default: m_data = m_a & m_b;
          endcase
          m_dv = 1; m_state = 3;
        end else begin
          m_dv = 0; m_state = 0;
        end
      end
    end
    cyc_n++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model, compare all outputs after the edge
  task automatic cyc(input logic [3:0] s, input logic [1:0] o,
                     input bit e, input bit m, input bit c, input bit r);
    sw = s; op_sel = o; btn_enter = e; btn_mode = m; btn_clear = c; reset = r;
    model_step();
    @(posedge clk);
    #1;
    chk("model_data",  int'(data),         m_data & 63);
    chk("model_valid", int'(data_valid),   int'(m_dv));
    chk("model_ovf",   int'(overflow),     int'(m_ov));
    chk("model_mode",  int'(display_mode), int'(m_mode));
    chk("model_state", int'(state),        m_state);
  endtask

  task automatic idle(input int n, input logic [3:0] s, input logic [1:0] o);
    repeat (n) cyc(s, o, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_enter(input logic [3:0] s, input logic [1:0] o);
    cyc(s, o, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(S + 2, s, o);
  endtask

  task automatic press_mode();
    cyc(4'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(S + 2, 4'd0, 2'b00);
  endtask

  task automatic entry(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o);
    press_enter(a, o);
    press_enter(b, o);
    press_enter(4'd0, o);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    int         exp_data;
    bit         exp_ov;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{4'd3,    4'b1011, 2'b00,  -2, 1'b0};
    vecs[1] = '{4'b1000, 4'b1000, 2'b10,  31, 1'b1};
    vecs[2] = '{4'b1000, 4'd7,    2'b10, -32, 1'b1};
    vecs[3] = '{4'b1000, 4'd4,    2'b10, -32, 1'b0};
    vecs[4] = '{4'b1000, 4'd7,    2'b01, -15, 1'b0};
    vecs[5] = '{4'b1101, 4'd6,    2'b11,   4, 1'b0};
    vecs[6] = '{4'd7,    4'd7,    2'b00,  14, 1'b0};
    vecs[7] = '{4'b1000, 4'b1000, 2'b00, -16, 1'b0};
    vecs[8] = '{4'd7,    4'b1000, 2'b01,  15, 1'b0};
    vecs[9] = '{4'b1111, 4'b1111, 2'b11,  -1, 1'b0};

    repeat (3) cyc(4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_data",  int'(data),         0);
    chk("reset_valid", int'(data_valid),   0);
    chk("reset_ovf",   int'(overflow),     0);
    chk("reset_mode",  int'(display_mode), 0);
    chk("reset_state", int'(state),        0);
    idle(2, 4'd0, 2'b00);

    for (int i = 0; i < 10; i++) begin
      entry(vecs[i].a, vecs[i].b, vecs[i].op);
      chk("vec_data",  int'($signed(data)), vecs[i].exp_data);
      chk("vec_ovf",   int'(overflow),      int'(vecs[i].exp_ov));
      chk("vec_valid", int'(data_valid),    1);
      chk("vec_state", int'(state),         3);
      press_enter(4'd0, vecs[i].op);
      chk("vec_back_valid", int'(data_valid),    0);
      chk("vec_hold_data",  int'($signed(data)), vecs[i].exp_data);
    end

    // Clear and enter together in S_OP: clear only
    press_enter(4'd2, 2'b00);
    press_enter(4'd3, 2'b00);
    cyc(4'd0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(S + 2, 4'd0, 2'b00);
    chk("clr_state", int'(state),      0);
    chk("clr_data",  int'(data),       0);
    chk("clr_valid", int'(data_valid), 0);

    // Enter held for 100 cycles gives a single capture
    repeat (100) cyc(4'd5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(S + 2, 4'd5, 2'b00);
    chk("held_state", int'(state), 1);

    // Reset in S_B with a=5 discards it
    repeat (2) cyc(4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rstB_state", int'(state),      0);
    chk("rstB_valid", int'(data_valid), 0);
    entry(4'd1, 4'd2, 2'b00);
    chk("rstB_data", int'($signed(data)), 3);

    // Mode presses toggle 1,0,1; a press inside reset leaves mode 0
    press_mode(); chk("mode_1", int'(display_mode), 1);
    press_mode(); chk("mode_2", int'(display_mode), 0);
    press_mode(); chk("mode_3", int'(display_mode), 1);
    cyc(4'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (S + 2) cyc(4'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(S + 3, 4'd0, 2'b00);
    chk("mode_rst", int'(display_mode), 0);

    // Mode press in S_RES leaves the result alone
    entry(4'd2, 4'd3, 2'b10);
    press_mode();
    chk("modeR_data",  int'($signed(data)), 6);
    chk("modeR_state", int'(state),         3);
    chk("modeR_mode",  int'(display_mode),  1);

    // Enter held across reset release yields one pulse
    repeat (3) cyc(4'd3, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (S + 12) cyc(4'd3, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("heldrst_state", int'(state), 1);
    idle(S + 2, 4'd0, 2'b00);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
